mips_single_cycle: RTL and testbench

Single-cycle MIPS-Lite CPU core: every instruction is fetched, decoded, executed and retired in one clock cycle. It contains its own byte-addressed instruction memory, data memory and 32×32 register file. Simulation benches preload these before releasing reset. It is the reference single-cycle datapath for the pipelined CPU project and is instantiated positionally as (clk, rst).

---
 rtl/mips_single_cycle.sv | 237 +++++++++++++++++++++++
 tb/tb_mips_single_cycle.sv | 409 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mips_single_cycle.sv
// mips_single_cycle: single-cycle MIPS-Lite core with built-in byte-addressed
// instruction memory (1 KiB), data memory (1 KiB) and a 32x32 register file.
// Every instruction is fetched, decoded, executed and retired in one clock.
// Optional feature macro: MIPS_SLL_EN turns R-type funct 0 into SLL
// (rd = rt << shamt); without it funct 0 is a pure NOP.

// Instruction memory: little-endian 32-bit fetch, addresses wrap at 1 KiB.
// The byte write port exists for loading and is tied off inside the core.
module mips_imem (
  input  logic        clk,
  input  logic        we,
  input  logic [9:0]  waddr,
  input  logic [7:0]  wdata,
  input  logic [9:0]  addr,
  output logic [31:0] instr
);
  logic [7:0] mem_array [0:1023];
  logic [9:0] a1, a2, a3;

  assign a1 = addr + 10'd1;
  assign a2 = addr + 10'd2;
  assign a3 = addr + 10'd3;

  // Byte loader port
  always_ff @(posedge clk) begin
    if (we) mem_array[waddr] <= wdata;
  end

  assign instr = {mem_array[a3], mem_array[a2], mem_array[a1], mem_array[addr]};
endmodule

// Data memory: little-endian word access, combinational read, clocked write.
// A word crossing byte 1023 wraps around to byte 0; alignment is not checked.
module mips_dmem (
  input  logic        clk,
  input  logic        we,
  input  logic [9:0]  addr,
  input  logic [31:0] wdata,
  output logic [31:0] rdata
);
  logic [7:0] mem_array [0:1023];
  logic [9:0] a1, a2, a3;

  assign a1 = addr + 10'd1;
  assign a2 = addr + 10'd2;
  assign a3 = addr + 10'd3;

  // Commit a store as four wrapped byte writes
  always_ff @(posedge clk) begin
    if (we) begin
      mem_array[addr] <= wdata[7:0];
      mem_array[a1]   <= wdata[15:8];
      mem_array[a2]   <= wdata[23:16];
      mem_array[a3]   <= wdata[31:24];
    end
  end

  assign rdata = {mem_array[a3], mem_array[a2], mem_array[a1], mem_array[addr]};
endmodule

// Register file: two combinational read ports, one clocked write port.
// $0 reads as zero regardless of array contents and ignores writes.
module mips_regfile (
  input  logic        clk,
  input  logic        we,
  input  logic [4:0]  ra1,
  input  logic [4:0]  ra2,
  input  logic [4:0]  wa,
  input  logic [31:0] wd,
  output logic [31:0] rd1,
  output logic [31:0] rd2
);
  logic [31:0] file_array [0:31];

  // Commit a register write, dropping writes aimed at $0
  always_ff @(posedge clk) begin
    if (we && (wa != 5'd0)) file_array[wa] <= wd;
  end

  assign rd1 = (ra1 == 5'd0) ? 32'd0 : file_array[ra1];
  assign rd2 = (ra2 == 5'd0) ? 32'd0 : file_array[ra2];
endmodule

module mips_single_cycle (
  input logic clk,
  input logic rst
);
  localparam logic [5:0] OP_RTYPE = 6'd0;
  localparam logic [5:0] OP_J     = 6'd2;
  localparam logic [5:0] OP_BEQ   = 6'd4;
  localparam logic [5:0] OP_ORI   = 6'd14;
  localparam logic [5:0] OP_LW    = 6'd35;
  localparam logic [5:0] OP_SW    = 6'd43;

  localparam logic [5:0] F_SLL = 6'd0;
  localparam logic [5:0] F_JR  = 6'd8;
  localparam logic [5:0] F_ADD = 6'd32;
  localparam logic [5:0] F_SUB = 6'd34;
  localparam logic [5:0] F_AND = 6'd36;
  localparam logic [5:0] F_OR  = 6'd37;

  typedef enum logic [2:0] {
    ALU_ADD,
    ALU_SUB,
    ALU_AND,
    ALU_OR,
    ALU_SLL
  } alu_op_t;

  logic [31:0] pc, next_pc, pc_plus4, instr;
  logic [5:0]  opcode, funct;
  logic [4:0]  rs_idx, rt_idx, rd_idx, shamt, rf_waddr;
  logic [15:0] imm;
  logic [31:0] simm, zimm, rs_val, rt_val, alu_b, alu_res, dm_rdata, rfile_wd;

  logic    rf_we, rf_dst_rd, alu_imm, imm_zext, mem_to_reg, dm_we;
  logic    branch, jump, jump_reg;
  alu_op_t alu_op;

  // Field extraction
  assign opcode = instr[31:26];
  assign rs_idx = instr[25:21];
  assign rt_idx = instr[20:16];
  assign rd_idx = instr[15:11];
  assign shamt  = instr[10:6];
  assign funct  = instr[5:0];
  assign imm    = instr[15:0];
  assign simm   = {{16{imm[15]}}, imm};
  assign zimm   = {16'd0, imm};

  assign pc_plus4 = pc + 32'd4;

  // PC register: reset pulls it to 0 immediately, independent of the clock
  always_ff @(posedge clk or posedge rst) begin
    if (rst) pc <= 32'd0;
    else     pc <= next_pc;
  end

  mips_imem InstrMem (
    .clk   (clk),
    .we    (1'b0),
    .waddr (10'd0),
    .wdata (8'd0),
    .addr  (pc[9:0]),
    .instr (instr)
  );

  // Main decoder: every control defaults to "do nothing", so unknown
  // opcodes and functs fall through as NOPs
  always_comb begin
    rf_we      = 1'b0;
    rf_dst_rd  = 1'b0;
    alu_imm    = 1'b0;
    imm_zext   = 1'b0;
    mem_to_reg = 1'b0;
    dm_we      = 1'b0;
    branch     = 1'b0;
    jump       = 1'b0;
    jump_reg   = 1'b0;
    alu_op     = ALU_ADD;
    case (opcode)
      OP_RTYPE: begin
        case (funct)
          F_ADD: begin rf_we = 1'b1; rf_dst_rd = 1'b1; alu_op = ALU_ADD; end
          F_SUB: begin rf_we = 1'b1; rf_dst_rd = 1'b1; alu_op = ALU_SUB; end
          F_AND: begin rf_we = 1'b1; rf_dst_rd = 1'b1; alu_op = ALU_AND; end
          F_OR:  begin rf_we = 1'b1; rf_dst_rd = 1'b1; alu_op = ALU_OR;  end
          F_JR:  jump_reg = 1'b1;
          F_SLL: begin
`ifdef MIPS_SLL_EN
            rf_we     = 1'b1;
            rf_dst_rd = 1'b1;
            alu_op    = ALU_SLL;
`endif
          end
          default: ;
        endcase
      end
      OP_ORI: begin rf_we = 1'b1; alu_imm = 1'b1; imm_zext = 1'b1; alu_op = ALU_OR; end
      OP_LW:  begin rf_we = 1'b1; alu_imm = 1'b1; mem_to_reg = 1'b1; end
      OP_SW:  begin dm_we = 1'b1; alu_imm = 1'b1; end
      OP_BEQ: begin branch = 1'b1; alu_op = ALU_SUB; end
      OP_J:   jump = 1'b1;
      default: ;
    endcase
  end

  assign rf_waddr = rf_dst_rd ? rd_idx : rt_idx;

  // No architectural writes while reset is held
  mips_regfile RegFile (
    .clk (clk),
    .we  (rf_we & ~rst),
    .ra1 (rs_idx),
    .ra2 (rt_idx),
    .wa  (rf_waddr),
    .wd  (rfile_wd),
    .rd1 (rs_val),
    .rd2 (rt_val)
  );

  assign alu_b = alu_imm ? (imm_zext ? zimm : simm) : rt_val;

  // ALU: all arithmetic wraps modulo 2^32
  always_comb begin
    alu_res = rs_val + alu_b;
    case (alu_op)
      ALU_ADD: alu_res = rs_val + alu_b;
      ALU_SUB: alu_res = rs_val - alu_b;
      ALU_AND: alu_res = rs_val & alu_b;
      ALU_OR:  alu_res = rs_val | alu_b;
      ALU_SLL: alu_res = alu_b << shamt;
      default: alu_res = rs_val + alu_b;
    endcase
  end

  mips_dmem DatMem (
    .clk   (clk),
    .we    (dm_we & ~rst),
    .addr  (alu_res[9:0]),
    .wdata (rt_val),
    .rdata (dm_rdata)
  );

  assign rfile_wd = mem_to_reg ? dm_rdata : alu_res;

  // Next-PC selection: JR, then J, then a taken BEQ, otherwise fall through
  always_comb begin
    next_pc = pc_plus4;
    if (jump_reg)
      next_pc = rs_val;
    else if (jump)
      next_pc = {pc_plus4[31:28], instr[25:0], 2'b00};
    else if (branch && (rs_val == rt_val))
      next_pc = pc_plus4 + {simm[29:0], 2'b00};
  end
endmodule

// File: tb/tb_mips_single_cycle.sv
// Self-checking bench for mips_single_cycle: directed programs, a vector
// table of single instructions, and a random program run against a
// behavioural instruction-level model.
module tb_mips_single_cycle;
  logic clk = 1'b0;
  logic rst = 1'b1;

  always #5 clk = ~clk;

  mips_single_cycle dut (
    .clk (clk),
    .rst (rst)
  );

  int total = 0;
  int bad   = 0;

  // Reference machine state
  logic [7:0]  m_imem [0:1023];
  logic [7:0]  m_dmem [0:1023];
  logic [31:0] m_reg  [0:31];
  logic [31:0] m_pc;

  typedef struct {
    string       name;
    logic [31:0] instr;
    logic [31:0] r1;
    logic [31:0] r2;
    logic        chk_wd;
    logic [31:0] exp_wd;
    logic [31:0] exp_pc;
    logic [31:0] exp_r3;
  } vec_t;

  vec_t vecs[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] enc_r(input int rs, input int rt, input int rd,
                                        input int sh, input int fn);
    return {6'd0, rs[4:0], rt[4:0], rd[4:0], sh[4:0], fn[5:0]};
  endfunction

  function automatic logic [31:0] enc_i(input int op, input int rs, input int rt,
                                        input logic [15:0] im);
    return {op[5:0], rs[4:0], rt[4:0], im};
  endfunction

  function automatic logic [31:0] enc_j(input logic [25:0] tgt);
    return {6'd2, tgt};
  endfunction

  task automatic put_word(input int a, input logic [31:0] w);
    for (int k = 0; k < 4; k++) begin
      dut.InstrMem.mem_array[(a + k) & 1023] = w[8*k +: 8];
      m_imem[(a + k) & 1023] = w[8*k +: 8];
    end
  endtask

  task automatic set_reg(input int i, input logic [31:0] v);
    dut.RegFile.file_array[i] = v;
    m_reg[i] = v;
  endtask

  task automatic clear_all();
    for (int i = 0; i < 1024; i++) begin
      dut.InstrMem.mem_array[i] = 8'd0;
      dut.DatMem.mem_array[i]   = 8'd0;
      m_imem[i] = 8'd0;
      m_dmem[i] = 8'd0;
    end
    for (int i = 0; i < 32; i++) set_reg(i, 32'd0);
  endtask

  // Raise reset at a falling edge so preloading happens with the core frozen
  task automatic begin_load();
    @(negedge clk);
    rst = 1'b1;
  endtask

  // Release at the next falling edge; reset spans one rising edge (10 ns)
  task automatic release_rst();
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Instruction-level reference: executes one instruction on the model state
  task automatic model_step(output logic wr, output logic [31:0] wd);
    logic [9:0]  pa, ea;
    logic [31:0] ins, a, b, sx, ea32, npc;
    logic [5:0]  op, fn;
    int          rs, rt, rd, dst;
    pa  = m_pc[9:0];
    ins = {m_imem[pa + 10'd3], m_imem[pa + 10'd2], m_imem[pa + 10'd1], m_imem[pa]};
    op  = ins[31:26];
    fn  = ins[5:0];
    rs  = int'(ins[25:21]);
    rt  = int'(ins[20:16]);
    rd  = int'(ins[15:11]);
    a   = (rs == 0) ? 32'd0 : m_reg[rs];
    b   = (rt == 0) ? 32'd0 : m_reg[rt];
    sx  = {{16{ins[15]}}, ins[15:0]};
    npc = m_pc + 32'd4;
    wr  = 1'b0;
    wd  = 32'd0;
    dst = 0;
    case (op)
      6'd0: begin
        case (fn)
          6'd32: begin wr = 1'b1; dst = rd; wd = a + b; end
          6'd34: begin wr = 1'b1; dst = rd; wd = a - b; end
          6'd36: begin wr = 1'b1; dst = rd; wd = a & b; end
          6'd37: begin wr = 1'b1; dst = rd; wd = a | b; end
          6'd8:  npc = a;
`ifdef MIPS_SLL_EN
          6'd0:  begin wr = 1'b1; dst = rd; wd = b << ins[10:6]; end
`endif
          default: ;
        endcase
      end
      6'd14: begin wr = 1'b1; dst = rt; wd = a | {16'd0, ins[15:0]}; end
      6'd35: begin
        ea32 = a + sx;
        ea   = ea32[9:0];
        wd   = {m_dmem[ea + 10'd3], m_dmem[ea + 10'd2], m_dmem[ea + 10'd1], m_dmem[ea]};
        wr   = 1'b1;
        dst  = rt;
      end
      6'd43: begin
        ea32 = a + sx;
        ea   = ea32[9:0];
        m_dmem[ea]         = b[7:0];
        m_dmem[ea + 10'd1] = b[15:8];
        m_dmem[ea + 10'd2] = b[23:16];
        m_dmem[ea + 10'd3] = b[31:24];
      end
      6'd4:  if (a == b) npc = npc + (sx << 2);
      6'd2:  npc = {npc[31:28], ins[25:0], 2'b00};
      default: ;
    endcase
    if (wr && dst != 0) m_reg[dst] = wd;
    m_pc = npc;
  endtask

  function automatic logic [31:0] rand_instr();
    int sel, f, op;
    sel = $urandom_range(0, 99);
    if (sel < 40) begin
      f = $urandom_range(0, 13);
      case (f)
        0, 1, 2:  return enc_r($urandom_range(0, 7), $urandom_range(0, 7), $urandom_range(0, 7), 0, 32);
        3, 4:     return enc_r($urandom_range(0, 7), $urandom_range(0, 7), $urandom_range(0, 7), 0, 34);
        5, 6:     return enc_r($urandom_range(0, 7), $urandom_range(0, 7), $urandom_range(0, 7), 0, 36);
        7, 8:     return enc_r($urandom_range(0, 7), $urandom_range(0, 7), $urandom_range(0, 7), 0, 37);
        9:        return enc_r($urandom_range(0, 7), $urandom_range(0, 7), $urandom_range(0, 7),
                               $urandom_range(0, 31), 0);
        10:       return enc_r($urandom_range(0, 7), 0, 0, 0, 8);
        default:  return enc_r($urandom_range(0, 7), $urandom_range(0, 7), $urandom_range(0, 7),
                               $urandom_range(0, 31), $urandom_range(0, 63));
      endcase
    end else if (sel < 55) begin
      return enc_i(14, $urandom_range(0, 7), $urandom_range(0, 7), 16'($urandom_range(0, 65535)));
    end else if (sel < 67) begin
      return enc_i(35, $urandom_range(0, 7), $urandom_range(0, 7), 16'($urandom_range(0, 65535)));
    end else if (sel < 79) begin
      return enc_i(43, $urandom_range(0, 7), $urandom_range(0, 7), 16'($urandom_range(0, 65535)));
    end else if (sel < 92) begin
      return enc_i(4, $urandom_range(0, 3), $urandom_range(0, 3), 16'($urandom_range(0, 65535)));
    end else if (sel < 95) begin
      return enc_j(26'($urandom()));
    end
    do op = $urandom_range(0, 63); while (op inside {0, 2, 4, 14, 35, 43});
    return {op[5:0], 26'($urandom())};
  endfunction

  // Runaway guard
  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    bad++;
    $display("test done: total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic        wr;
    logic [31:0] wd, w;
    logic [31:0] alu_exp [6];

    // ---------------- Reset and fetch ----------------
    begin_load();
    clear_all();
    put_word(0, 32'h01224820);            // add $9,$9,$2
    set_reg(9, 32'd5);
    set_reg(2, 32'd7);
    #1;
    check("rst_pc", dut.pc, 32'd0);
    check("rst_opcode", {26'd0, dut.opcode}, 32'd0);
    check("rst_funct", {26'd0, dut.funct}, 32'd32);
    release_rst();
    #1;
    check("fetch_wd", dut.rfile_wd, 32'd12);
    step();
    check("fetch_r9", dut.RegFile.file_array[9], 32'd12);
    check("fetch_pc", dut.pc, 32'd4);

    // ---------------- ALU mix ----------------
    begin_load();
    clear_all();
    set_reg(1, 32'h000000F0);
    set_reg(2, 32'h0000003C);
    put_word(0,  enc_r(1, 2, 3, 0, 34));
    put_word(4,  enc_r(1, 2, 4, 0, 36));
    put_word(8,  enc_r(1, 2, 5, 0, 37));
    put_word(12, enc_i(14, 1, 3, 16'h000F));
    put_word(16, enc_r(1, 2, 0, 0, 32));
    put_word(20, enc_r(0, 0, 6, 0, 37));
    alu_exp[0] = 32'hB4; alu_exp[1] = 32'h30; alu_exp[2] = 32'hFC;
    alu_exp[3] = 32'hFF; alu_exp[4] = 32'h12C; alu_exp[5] = 32'h0;
    release_rst();
    #1;
    for (int k = 0; k < 6; k++) begin
      check($sformatf("alu_wd%0d", k), dut.rfile_wd, alu_exp[k]);
      step();
    end
    check("alu_r0", dut.RegFile.file_array[0], 32'd0);
    check("alu_r3", dut.RegFile.file_array[3], 32'hFF);
    check("alu_r4", dut.RegFile.file_array[4], 32'h30);
    check("alu_r5", dut.RegFile.file_array[5], 32'hFC);

    // ---------------- Memory ----------------
    begin_load();
    clear_all();
    set_reg(2, 32'h11223344);
    put_word(0,  enc_i(43, 0, 2, 16'd8));     // sw $2,8($0)
    put_word(4,  enc_i(35, 0, 5, 16'd8));     // lw $5,8($0)
    put_word(8,  enc_i(43, 0, 2, 16'd1022));  // sw wrapping past byte 1023
    put_word(12, enc_i(35, 0, 6, 16'd1022));
    put_word(16, enc_i(35, 0, 7, 16'd9));     // unaligned load
    release_rst();
    #1;
    step();
    w = 32'h11223344;
    for (int k = 0; k < 4; k++)
      check($sformatf("sw_byte%0d", 8 + k), {24'd0, dut.DatMem.mem_array[8 + k]}, {24'd0, w[8*k +: 8]});
    check("lw_wd", dut.rfile_wd, 32'h11223344);
    step();
    check("lw_r5", dut.RegFile.file_array[5], 32'h11223344);
    step();
    check("sw_wrap_b1022", {24'd0, dut.DatMem.mem_array[1022]}, 32'h44);
    check("sw_wrap_b1023", {24'd0, dut.DatMem.mem_array[1023]}, 32'h33);
    check("sw_wrap_b0",    {24'd0, dut.DatMem.mem_array[0]},    32'h22);
    check("sw_wrap_b1",    {24'd0, dut.DatMem.mem_array[1]},    32'h11);
    step();
    check("lw_wrap_r6", dut.RegFile.file_array[6], 32'h11223344);
    check("lw_unal_wd", dut.rfile_wd, 32'h00112233);
    step();
    check("lw_unal_r7", dut.RegFile.file_array[7], 32'h00112233);

    // ---------------- Branches ----------------
    begin_load();
    clear_all();
    set_reg(1, 32'd5);
    set_reg(2, 32'd6);
    put_word(16, enc_i(4, 1, 1, 16'hFFFF));
    release_rst();
    #1;
    for (int k = 0; k < 4; k++) step();
    check("beq_reach", dut.pc, 32'h10);
    step();
    check("beq_taken1", dut.pc, 32'h10);
    step();
    check("beq_taken2", dut.pc, 32'h10);

    begin_load();
    clear_all();
    set_reg(1, 32'd5);
    set_reg(2, 32'd6);
    put_word(16, enc_i(4, 1, 2, 16'hFFFF));
    release_rst();
    #1;
    for (int k = 0; k < 5; k++) step();
    check("beq_not_taken", dut.pc, 32'h14);

    // ---------------- Jumps ----------------
    begin_load();
    clear_all();
    set_reg(31, 32'h8);
    put_word(32, enc_j(26'h10));
    put_word(64, enc_r(31, 0, 0, 0, 8));
    release_rst();
    #1;
    for (int k = 0; k < 8; k++) step();
    check("j_reach", dut.pc, 32'h20);
    step();
    check("j_target", dut.pc, 32'h40);
    step();
    check("jr_target", dut.pc, 32'h8);

    // ---------------- Async reset mid-run ----------------
    begin_load();
    clear_all();
    set_reg(2, 32'd1);
    for (int a = 0; a < 64; a += 4) put_word(a, enc_r(9, 2, 9, 0, 32));
    release_rst();
    #1;
    for (int k = 0; k < 7; k++) step();
    check("ar_pc_before", dut.pc, 32'h1C);
    #2;
    rst = 1'b1;
    #1;
    check("ar_pc_async", dut.pc, 32'd0);
    check("ar_r9_kept", dut.RegFile.file_array[9], 32'd7);
    step();
    check("ar_pc_held", dut.pc, 32'd0);
    check("ar_r9_frozen", dut.RegFile.file_array[9], 32'd7);
    release_rst();
    #1;
    step();
    check("ar_pc_restart", dut.pc, 32'd4);
    check("ar_r9_resume", dut.RegFile.file_array[9], 32'd8);

    // ---------------- Single-instruction vector table ----------------
    vecs.push_back('{"add_wrap", enc_r(1, 2, 3, 0, 32), 32'hFFFFFFFF, 32'd2, 1'b1, 32'd1, 32'd4, 32'd1});
    vecs.push_back('{"sub_neg", enc_r(1, 2, 3, 0, 34), 32'd0, 32'd1, 1'b1, 32'hFFFFFFFF, 32'd4, 32'hFFFFFFFF});
    vecs.push_back('{"and", enc_r(1, 2, 3, 0, 36), 32'hA5A5F00F, 32'h0FF0FFFF, 1'b1, 32'h05A0F00F, 32'd4, 32'h05A0F00F});
    vecs.push_back('{"or", enc_r(1, 2, 3, 0, 37), 32'h12000034, 32'h00560078, 1'b1, 32'h1256007C, 32'd4, 32'h1256007C});
    vecs.push_back('{"ori_zext", enc_i(14, 1, 3, 16'hFFFF), 32'h12340000, 32'd0, 1'b1, 32'h1234FFFF, 32'd4, 32'h1234FFFF});
    vecs.push_back('{"lw_negoff", enc_i(35, 1, 3, 16'hFFFC), 32'h0C, 32'd0, 1'b1, 32'h0B0A0908, 32'd4, 32'h0B0A0908});
    vecs.push_back('{"lw_wrap", enc_i(35, 1, 3, 16'h0000), 32'h000007FE, 32'd0, 1'b1, 32'h0100FFFE, 32'd4, 32'h0100FFFE});
    vecs.push_back('{"bad_funct", enc_r(1, 2, 3, 0, 42), 32'd1, 32'd2, 1'b0, 32'd0, 32'd4, 32'hDEADBEEF});
    vecs.push_back('{"bad_opcode", enc_i(63, 1, 3, 16'h1234), 32'd1, 32'd2, 1'b0, 32'd0, 32'd4, 32'hDEADBEEF});
`ifdef MIPS_SLL_EN
    vecs.push_back('{"funct0_sll", enc_r(1, 2, 3, 4, 0), 32'd1, 32'h0F00000F, 1'b1, 32'hF00000F0, 32'd4, 32'hF00000F0});
`else
    vecs.push_back('{"funct0_nop", enc_r(1, 2, 3, 4, 0), 32'd1, 32'h0F00000F, 1'b0, 32'd0, 32'd4, 32'hDEADBEEF});
`endif
    vecs.push_back('{"jr", enc_r(1, 0, 0, 0, 8), 32'h100, 32'd0, 1'b0, 32'd0, 32'h100, 32'hDEADBEEF});
    vecs.push_back('{"beq_far", enc_i(4, 1, 2, 16'h7FFF), 32'd7, 32'd7, 1'b0, 32'd0, 32'h00020000, 32'hDEADBEEF});
    vecs.push_back('{"beq_ne", enc_i(4, 1, 2, 16'h7FFF), 32'd7, 32'd8, 1'b0, 32'd0, 32'd4, 32'hDEADBEEF});
    vecs.push_back('{"j_max", enc_j(26'h3FFFFFF), 32'd0, 32'd0, 1'b0, 32'd0, 32'h0FFFFFFC, 32'hDEADBEEF});
    vecs.push_back('{"add_r0", enc_r(1, 2, 0, 0, 32), 32'd1, 32'd2, 1'b1, 32'd3, 32'd4, 32'hDEADBEEF});
    vecs.push_back('{"sw_noreg", enc_i(43, 1, 3, 16'd0), 32'h40, 32'd0, 1'b0, 32'd0, 32'd4, 32'hDEADBEEF});

    foreach (vecs[i]) begin
      begin_load();
      clear_all();
      for (int a = 0; a < 1024; a++) dut.DatMem.mem_array[a] = 8'(a);
      set_reg(1, vecs[i].r1);
      set_reg(2, vecs[i].r2);
      set_reg(3, 32'hDEADBEEF);
      put_word(0, vecs[i].instr);
      release_rst();
      #1;
      if (vecs[i].chk_wd) check({vecs[i].name, "_wd"}, dut.rfile_wd, vecs[i].exp_wd);
      step();
      check({vecs[i].name, "_pc"}, dut.pc, vecs[i].exp_pc);
      check({vecs[i].name, "_r3"}, dut.RegFile.file_array[3], vecs[i].exp_r3);
      check({vecs[i].name, "_r0"}, dut.RegFile.file_array[0], 32'd0);
    end

    // ---------------- Random program against the model ----------------
    begin_load();
    for (int a = 0; a < 1024; a += 4) put_word(a, rand_instr());
    for (int a = 0; a < 1024; a++) begin
      w = $urandom();
      dut.DatMem.mem_array[a] = w[7:0];
      m_dmem[a] = w[7:0];
    end
    set_reg(0, 32'd0);
    for (int r = 1; r < 32; r++) set_reg(r, $urandom());
    m_pc = 32'd0;
    release_rst();
    #1;
    for (int i = 0; i < 1500; i++) begin
      if (i == 700) begin
        #2;
        rst = 1'b1;
        #1;
        check("rnd_async_pc", dut.pc, 32'd0);
        step();
        rst = 1'b0;
        m_pc = 32'd0;
      end
      check($sformatf("rnd_pc_%0d", i), dut.pc, m_pc);
      model_step(wr, wd);
      if (wr) check($sformatf("rnd_wd_%0d", i), dut.rfile_wd, wd);
      step();
    end
    for (int r = 1; r < 32; r++)
      check($sformatf("rnd_reg%0d", r), dut.RegFile.file_array[r], m_reg[r]);
    for (int a = 0; a < 1024; a++)
      check($sformatf("rnd_mem%0d", a), {24'd0, dut.DatMem.mem_array[a]}, {24'd0, m_dmem[a]});

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
